// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared edge/center-aligned period counter,
// per-channel duty registers adjusted by debounced inc/dec buttons, shadowed at period boundaries.
module pwm_multi_channel #(
  parameter int unsigned CH         = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DEB_DIV    = 4,
  parameter int unsigned STEP       = 1,
  parameter int unsigned DUTY_RST   = 0,
  parameter int unsigned PERIOD_RST = 10,
  localparam int unsigned SEL_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             center,
  input  logic [CNT_W-1:0] period,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic [SEL_W-1:0] ch_sel,
  output logic [CH-1:0]    pwm_out,
  output logic [CNT_W-1:0] duty_rd,
  output logic             period_end
);

  localparam int unsigned TICK_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              inc_s1, inc_s2, dec_s1, dec_s2;
  logic              ev_inc, ev_dec;

  logic [CNT_W-1:0]  duty     [CH];
  logic [CNT_W-1:0]  duty_act [CH];
  logic [CNT_W-1:0]  duty_new;
  logic [CNT_W:0]    per_lim, inc_sum, dec_dif;

  logic [CNT_W-1:0]  cnt, cnt_nxt, per_act, per_last;
  dir_t              dir, dir_nxt;
  logic              mode_act;
  logic              boundary;

  assign tick = (tick_cnt == TICK_W'(DEB_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      inc_s1   <= 1'b0;
      inc_s2   <= 1'b0;
      dec_s1   <= 1'b0;
      dec_s2   <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      if (tick) begin
        inc_s1 <= btn_inc;
        inc_s2 <= inc_s1;
        dec_s1 <= btn_dec;
        dec_s2 <= dec_s1;
      end
    end
  end

  assign ev_inc = inc_s1 & ~inc_s2 & tick;
  assign ev_dec = dec_s1 & ~dec_s2 & tick;

  // An out-of-range ch_sel matches no channel: reads 0 and writes nothing.
  always_comb begin
    duty_rd = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (ch_sel == SEL_W'(i)) duty_rd = duty[i];
    end
  end

  // Arithmetic is one bit wider so saturation at both ends never wraps.
  always_comb begin
    per_lim = (period == '0) ? (CNT_W+1)'(1) : {1'b0, period};
    inc_sum = {1'b0, duty_rd} + (CNT_W+1)'(STEP);
    dec_dif = {1'b0, duty_rd} - (CNT_W+1)'(STEP);
    if (ev_inc) begin
      duty_new = (inc_sum > per_lim) ? per_lim[CNT_W-1:0] : inc_sum[CNT_W-1:0];
    end else begin
      duty_new = dec_dif[CNT_W] ? '0 : dec_dif[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) duty[i] <= CNT_W'(DUTY_RST);
    end else if (ev_inc ^ ev_dec) begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (ch_sel == SEL_W'(i)) duty[i] <= duty_new;
      end
    end
  end

  assign per_last = per_act - CNT_W'(1);

  // Center mode holds the top value for one extra cycle while turning around.
  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (en) begin
      if (!mode_act) begin
        if (cnt == per_last) boundary = 1'b1;
        else                 cnt_nxt  = cnt + CNT_W'(1);
      end else if (dir == DIR_DOWN) begin
        if (cnt == '0) boundary = 1'b1;
        else           cnt_nxt  = cnt - CNT_W'(1);
      end else if (cnt == per_last) begin
        dir_nxt = DIR_DOWN;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
      if (boundary) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dir        <= DIR_UP;
      per_act    <= CNT_W'(PERIOD_RST);
      mode_act   <= 1'b0;
      pwm_out    <= '0;
      period_end <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) duty_act[i] <= CNT_W'(DUTY_RST);
    end else begin
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      period_end <= boundary;
      for (int unsigned i = 0; i < CH; i++) begin
        pwm_out[i] <= en & (cnt < duty_act[i]);
      end
      if (boundary) begin
        per_act  <= per_lim[CNT_W-1:0];
        mode_act <= center;
        for (int unsigned i = 0; i < CH; i++) duty_act[i] <= duty[i];
      end
    end
  end

endmodule
